csr_trap_ctrl: RTL and testbench

- Trap/return sequencer in front of the single CSR write port (WEn/WAddr/WDate).
- Takes commit-stage interrupt, exception, ERTN and CSR-instruction write requests and arbitrates between them.
- For a trap, serialises the hardware CSR updates (ERA, PRMD, ESTAT, BADV, CRMD) one per cycle, stalling the pipeline, then issues a flush plus redirect PC.
- For ERTN, restores CRMD from PRMD and redirects to ERA.

---
 rtl/csr_trap_ctrl_pkg.sv | 40 ++++
 rtl/csr_trap_ctrl_if.sv | 26 ++
 rtl/csr_trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the trap/return sequencer: CSR addresses, CSR bit-field
// positions, the TLB-refill Ecode and the sequencer state encoding.
package csr_trap_ctrl_pkg;

  localparam int CSR_DATA_W = 32;
  localparam int CSR_ADDR_W = 14;

  localparam logic [5:0] ECODE_TLBR_DEF = 6'h3F;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECTL      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  localparam int CRMD_PLV    = 0;   // 2 bits
  localparam int CRMD_IE     = 2;
  localparam int CRMD_DA     = 3;
  localparam int CRMD_PG     = 4;
  localparam int PRMD_PPLV   = 0;   // 2 bits
  localparam int PRMD_PIE    = 2;
  localparam int ESTAT_IS_W  = 13;  // interrupt status/enable lines
  localparam int ESTAT_ECODE = 16;  // 6 bits
  localparam int ESTAT_ESUB  = 22;  // 9 bits

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_ERA,
    S_T_PRMD,
    S_T_ESTAT,
    S_T_BADV,
    S_T_CRMD,
    S_E_CRMD,
    S_REDIR
  } trapState_e;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// CSR write bus: the CSR-instruction write request and the single CSR write
// port that the sequencer drives on its behalf or for hardware trap updates.
interface csr_trap_ctrl_if
  import csr_trap_ctrl_pkg::*;
#(
  parameter int DATA_W = CSR_DATA_W,
  parameter int ADDR_W = CSR_ADDR_W
);
  logic              InstCsrWe;
  logic [ADDR_W-1:0] InstCsrAddr;
  logic [DATA_W-1:0] InstCsrData;
  logic              InstCsrReady;
  logic              WEn;
  logic [ADDR_W-1:0] WAddr;
  logic [DATA_W-1:0] WDate;

  modport master (
    input  InstCsrWe, InstCsrAddr, InstCsrData,
    output InstCsrReady, WEn, WAddr, WDate
  );

  modport slave (
    output InstCsrWe, InstCsrAddr, InstCsrData,
    input  InstCsrReady, WEn, WAddr, WDate
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer owning the CSR write port: arbitrates commit-stage
// traps, ERTN and CSR-instruction writes, serialising trap CSR updates.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int         DATA_W     = CSR_DATA_W,
  parameter int         ADDR_W     = CSR_ADDR_W,
  parameter logic [5:0] ECODE_TLBR = ECODE_TLBR_DEF
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              CommitValid,
  input  logic [DATA_W-1:0] CommitPc,
  input  logic              ExcpValid,
  input  logic [5:0]        ExcpEcode,
  input  logic [8:0]        ExcpEsub,
  input  logic              BadvValid,
  input  logic [DATA_W-1:0] BadvAddr,
  input  logic              Ertn,
  input  logic [DATA_W-1:0] CsrCrmd,
  input  logic [DATA_W-1:0] CsrPrmd,
  input  logic [DATA_W-1:0] CsrEstat,
  input  logic [DATA_W-1:0] CsrEctl,
  input  logic [DATA_W-1:0] CsrEra,
  input  logic [DATA_W-1:0] CsrEentry,
  input  logic [DATA_W-1:0] CsrTlbrentry,
  csr_trap_ctrl_if.master   csrBus,
  output logic              TrapStall,
  output logic              Flush,
  output logic [DATA_W-1:0] RedirectPc
);

  trapState_e stateQ, stateD;

  logic [DATA_W-1:0]     pcQ, badvQ, crmdQ, targetQ;
  logic [ESTAT_ESUB-1:0] estatQ;
  logic [5:0]            ecodeQ;
  logic [8:0]            esubQ;
  logic                  badvValidQ;

  logic              intPend, isIdle, trapAcc, ertnAcc;
  logic [5:0]        ecodeSel;
  logic [DATA_W-1:0] wrData;
  logic              unusedBits;

  assign intPend = CsrCrmd[CRMD_IE] & (|(CsrEstat[ESTAT_IS_W-1:0] & CsrEctl[ESTAT_IS_W-1:0]));
  assign isIdle  = (stateQ == S_IDLE);
  assign trapAcc = isIdle & CommitValid & (intPend | ExcpValid);
  assign ertnAcc = isIdle & CommitValid & ~intPend & ~ExcpValid & Ertn;
  // Interrupts outrank the committing instruction's own exception.
  assign ecodeSel = intPend ? 6'd0 : ExcpEcode;

  assign unusedBits = ^{CsrEctl[DATA_W-1:ESTAT_IS_W], CsrPrmd[DATA_W-1:PRMD_PIE+1],
                        CsrEstat[DATA_W-1:ESTAT_ESUB]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) stateQ <= S_IDLE;
    else       stateQ <= stateD;
  end

  // NOTE: capture registers are reset as well; they are few and a known value
  // keeps post-reset behaviour deterministic.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      pcQ        <= '0;
      badvQ      <= '0;
      crmdQ      <= '0;
      estatQ     <= '0;
      targetQ    <= '0;
      ecodeQ     <= '0;
      esubQ      <= '0;
      badvValidQ <= 1'b0;
    end else if (trapAcc) begin
      pcQ        <= CommitPc;
      ecodeQ     <= ecodeSel;
      esubQ      <= intPend ? 9'd0 : ExcpEsub;
      badvValidQ <= ~intPend & BadvValid;
      badvQ      <= BadvAddr;
      crmdQ      <= CsrCrmd;
      estatQ     <= CsrEstat[ESTAT_ESUB-1:0];
      targetQ    <= (ecodeSel == ECODE_TLBR) ? CsrTlbrentry : CsrEentry;
    end else if (ertnAcc) begin
      crmdQ      <= CsrCrmd;
      estatQ     <= CsrEstat[ESTAT_ESUB-1:0];
      targetQ    <= CsrEra;
    end
  end

  // NOTE: every output and next-state variable gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    stateD              = stateQ;
    wrData              = '0;
    csrBus.WEn          = 1'b0;
    csrBus.WAddr        = '0;
    csrBus.InstCsrReady = 1'b0;
    Flush               = 1'b0;
    RedirectPc          = '0;
    TrapStall           = ~isIdle;

    unique case (stateQ)
      S_IDLE: begin
        if (trapAcc) begin
          stateD = S_T_ERA;
        end else begin
          if (ertnAcc) stateD = S_E_CRMD;
          // Pass-through is gated by reset so the bus is quiet while held.
          if (Rest) begin
            csrBus.InstCsrReady = 1'b1;
            if (csrBus.InstCsrWe) begin
              csrBus.WEn   = 1'b1;
              csrBus.WAddr = csrBus.InstCsrAddr;
              wrData       = csrBus.InstCsrData;
            end
          end
        end
      end
      S_T_ERA: begin
        csrBus.WEn   = 1'b1;
        csrBus.WAddr = ADDR_W'(CSR_ERA);
        wrData       = pcQ;
        stateD       = S_T_PRMD;
      end
      S_T_PRMD: begin
        csrBus.WEn                = 1'b1;
        csrBus.WAddr              = ADDR_W'(CSR_PRMD);
        wrData[PRMD_PPLV +: 2]    = crmdQ[CRMD_PLV +: 2];
        wrData[PRMD_PIE]          = crmdQ[CRMD_IE];
        stateD                    = S_T_ESTAT;
      end
      S_T_ESTAT: begin
        csrBus.WEn                = 1'b1;
        csrBus.WAddr              = ADDR_W'(CSR_ESTAT);
        wrData[15:0]              = estatQ[15:0];
        wrData[ESTAT_ECODE +: 6]  = ecodeQ;
        wrData[ESTAT_ESUB +: 9]   = esubQ;
        stateD                    = badvValidQ ? S_T_BADV : S_T_CRMD;
      end
      S_T_BADV: begin
        csrBus.WEn   = 1'b1;
        csrBus.WAddr = ADDR_W'(CSR_BADV);
        wrData       = badvQ;
        stateD       = S_T_CRMD;
      end
      S_T_CRMD: begin
        csrBus.WEn             = 1'b1;
        csrBus.WAddr           = ADDR_W'(CSR_CRMD);
        wrData                 = crmdQ;
        wrData[CRMD_PLV +: 2]  = 2'b00;
        wrData[CRMD_IE]        = 1'b0;
        if (ecodeQ == ECODE_TLBR) begin
          wrData[CRMD_DA] = 1'b1;
          wrData[CRMD_PG] = 1'b0;
        end
        stateD = S_REDIR;
      end
      S_E_CRMD: begin
        csrBus.WEn             = 1'b1;
        csrBus.WAddr           = ADDR_W'(CSR_CRMD);
        wrData                 = crmdQ;
        wrData[CRMD_PLV +: 2]  = CsrPrmd[PRMD_PPLV +: 2];
        wrData[CRMD_IE]        = CsrPrmd[PRMD_PIE];
        if (estatQ[ESTAT_ECODE +: 6] == ECODE_TLBR) begin
          wrData[CRMD_DA] = 1'b0;
          wrData[CRMD_PG] = 1'b1;
        end
        stateD = S_REDIR;
      end
      S_REDIR: begin
        Flush      = 1'b1;
        RedirectPc = targetQ;
        stateD     = S_IDLE;
      end
      default: stateD = S_IDLE;
    endcase

    csrBus.WDate = wrData;
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Randomised self-checking bench for csr_trap_ctrl; expected CSR write lists,
// flush latency and redirect target come from an arithmetic reference model.
module tb_csr_trap_ctrl;
  import csr_trap_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Rest = 1'b0;
  logic        CommitValid = 1'b0;
  logic [31:0] CommitPc = '0;
  logic        ExcpValid = 1'b0;
  logic [5:0]  ExcpEcode = '0;
  logic [8:0]  ExcpEsub = '0;
  logic        BadvValid = 1'b0;
  logic [31:0] BadvAddr = '0;
  logic        Ertn = 1'b0;
  logic [31:0] CsrCrmd = '0, CsrPrmd = '0, CsrEstat = '0, CsrEctl = '0;
  logic [31:0] CsrEra = '0, CsrEentry = '0, CsrTlbrentry = '0;
  logic        TrapStall, Flush;
  logic [31:0] RedirectPc;

  csr_trap_ctrl_if #(.DATA_W(32), .ADDR_W(14)) bus ();

  csr_trap_ctrl dut (
    .Clk(Clk), .Rest(Rest),
    .CommitValid(CommitValid), .CommitPc(CommitPc),
    .ExcpValid(ExcpValid), .ExcpEcode(ExcpEcode), .ExcpEsub(ExcpEsub),
    .BadvValid(BadvValid), .BadvAddr(BadvAddr), .Ertn(Ertn),
    .CsrCrmd(CsrCrmd), .CsrPrmd(CsrPrmd), .CsrEstat(CsrEstat), .CsrEctl(CsrEctl),
    .CsrEra(CsrEra), .CsrEentry(CsrEentry), .CsrTlbrentry(CsrTlbrentry),
    .csrBus(bus),
    .TrapStall(TrapStall), .Flush(Flush), .RedirectPc(RedirectPc)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one commit-stage request and follows any resulting sequence to its end.
  task automatic runTxn(input string tag, input logic [31:0] pc, input logic excp,
                        input logic [5:0] ec, input logic [8:0] es, input logic bv,
                        input logic [31:0] ba, input logic ertn, input logic instWe,
                        input logic [13:0] instAddr, input logic [31:0] instData);
    wr_t         expQ[$];
    logic        intPend, gotFlush;
    logic [5:0]  ecE;
    logic [8:0]  esE;
    logic        bvE;
    logic [31:0] target, crmdNew, estatNew;
    logic [13:0] pendAddr;
    logic [31:0] pendData;
    int          kind, lat, nWr;

    intPend = CsrCrmd[2] && ((CsrEstat & CsrEctl & 32'h1FFF) != 0);
    kind    = (intPend || excp) ? 1 : (ertn ? 2 : 0);
    ecE     = intPend ? 6'd0 : ec;
    esE     = intPend ? 9'd0 : es;
    bvE     = intPend ? 1'b0 : bv;
    target  = '0;
    if (kind == 1) begin
      estatNew = (32'(esE) << 22) | (32'(ecE) << 16) | (CsrEstat & 32'hFFFF);
      crmdNew  = CsrCrmd & ~32'h7;
      if (ecE == 6'h3F) crmdNew = (crmdNew | 32'h8) & ~32'h10;
      expQ.push_back('{CSR_ERA, pc});
      expQ.push_back('{CSR_PRMD, CsrCrmd & 32'h7});
      expQ.push_back('{CSR_ESTAT, estatNew});
      if (bvE) expQ.push_back('{CSR_BADV, ba});
      expQ.push_back('{CSR_CRMD, crmdNew});
      target = (ecE == 6'h3F) ? CsrTlbrentry : CsrEentry;
    end else if (kind == 2) begin
      crmdNew = (CsrCrmd & ~32'h7) | (CsrPrmd & 32'h7);
      if (((CsrEstat >> 16) & 32'h3F) == 32'h3F) crmdNew = (crmdNew & ~32'h8) | 32'h10;
      expQ.push_back('{CSR_CRMD, crmdNew});
      target = CsrEra;
    end
    lat = expQ.size() + 1;

    @(negedge Clk);
    CommitValid = 1'b1; CommitPc = pc; ExcpValid = excp; ExcpEcode = ec; ExcpEsub = es;
    BadvValid = bv; BadvAddr = ba; Ertn = ertn;
    bus.InstCsrWe = instWe; bus.InstCsrAddr = instAddr; bus.InstCsrData = instData;
    #2;
    check({tag, ".acc_stall"}, TrapStall, 0);
    check({tag, ".acc_flush"}, Flush, 0);
    if (kind == 1) begin
      check({tag, ".acc_wen"}, bus.WEn, 0);
      check({tag, ".acc_ready"}, bus.InstCsrReady, 0);
    end else begin
      check({tag, ".acc_ready"}, bus.InstCsrReady, 1);
      check({tag, ".acc_wen"}, bus.WEn, instWe);
      if (instWe) begin
        check({tag, ".acc_waddr"}, bus.WAddr, instAddr);
        check({tag, ".acc_wdata"}, bus.WDate, instData);
      end
    end

    if (kind == 0) begin
      @(negedge Clk);
      CommitValid = 1'b0; ExcpValid = 1'b0; Ertn = 1'b0; bus.InstCsrWe = 1'b0;
      return;
    end

    pendAddr = 14'($urandom);
    pendData = $urandom;
    gotFlush = 1'b0;
    nWr      = 0;
    for (int c = 1; c <= 10 && !gotFlush; c++) begin
      @(negedge Clk);
      CommitValid = 1'($urandom_range(0, 1));
      ExcpValid   = 1'($urandom_range(0, 1));
      Ertn        = 1'($urandom_range(0, 1));
      CommitPc    = $urandom;
      bus.InstCsrWe = 1'b1; bus.InstCsrAddr = pendAddr; bus.InstCsrData = pendData;
      #2;
      check({tag, ".seq_stall"}, TrapStall, 1);
      check({tag, ".seq_ready"}, bus.InstCsrReady, 0);
      if (bus.WEn) begin
        if (nWr < expQ.size()) begin
          check({tag, ".wr_addr"}, bus.WAddr, expQ[nWr].addr);
          check({tag, ".wr_data"}, bus.WDate, expQ[nWr].data);
        end
        nWr++;
      end
      if (Flush) begin
        gotFlush = 1'b1;
        check({tag, ".flush_cycle"}, c, lat);
        check({tag, ".redirect"}, RedirectPc, target);
      end
    end
    check({tag, ".flush_seen"}, gotFlush, 1);
    check({tag, ".num_writes"}, nWr, expQ.size());

    @(negedge Clk);
    CommitValid = 1'b0; ExcpValid = 1'b0; Ertn = 1'b0;
    #2;
    check({tag, ".post_stall"}, TrapStall, 0);
    check({tag, ".post_flush"}, Flush, 0);
    check({tag, ".post_wen"}, bus.WEn, 1);
    check({tag, ".post_waddr"}, bus.WAddr, pendAddr);
    check({tag, ".post_wdata"}, bus.WDate, pendData);
    check({tag, ".post_ready"}, bus.InstCsrReady, 1);
    @(negedge Clk);
    bus.InstCsrWe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Held in reset with a pending CSR-instruction write: bus must stay quiet.
    bus.InstCsrWe = 1'b1; bus.InstCsrAddr = 14'h030; bus.InstCsrData = 32'h1234;
    #1;
    check("rst.wen", bus.WEn, 0);
    check("rst.waddr", bus.WAddr, 0);
    check("rst.wdata", bus.WDate, 0);
    check("rst.ready", bus.InstCsrReady, 0);
    check("rst.stall", TrapStall, 0);
    check("rst.flush", Flush, 0);
    check("rst.redirect", RedirectPc, 0);

    @(negedge Clk);
    Rest = 1'b1;
    #2;
    check("pass.wen", bus.WEn, 1);
    check("pass.waddr", bus.WAddr, 14'h030);
    check("pass.wdata", bus.WDate, 32'h1234);
    check("pass.ready", bus.InstCsrReady, 1);
    @(negedge Clk);
    bus.InstCsrWe = 1'b0;

    CsrEentry = 32'h1C008000; CsrTlbrentry = 32'h00001000; CsrEra = 32'h1C000200;
    CsrCrmd = 32'h0000000B; CsrEstat = 32'h0; CsrEctl = 32'h0; CsrPrmd = 32'h0;
    runTxn("excp", 32'h1C000100, 1'b1, 6'h08, 9'h0, 1'b0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);

    CsrCrmd = 32'h00000013;
    runTxn("tlbr", 32'h1C000300, 1'b1, 6'h3F, 9'h0, 1'b1, 32'h00400000, 1'b0, 1'b0, 14'h0, 32'h0);

    CsrCrmd = 32'h00000004; CsrEstat = 32'h00000800; CsrEctl = 32'h00000800;
    runTxn("intr", 32'h1C000400, 1'b1, 6'h08, 9'h1, 1'b1, 32'hDEAD0000, 1'b0, 1'b1, 14'h040, 32'h55AA);

    CsrCrmd = 32'h00000008; CsrEstat = 32'h0; CsrEctl = 32'h0; CsrPrmd = 32'h00000007;
    runTxn("ertn", 32'h1C000500, 1'b0, 6'h0, 9'h0, 1'b0, 32'h0, 1'b1, 1'b0, 14'h0, 32'h0);

    // Reset in the middle of a trap sequence while a CSR-instruction write waits.
    CsrCrmd = 32'h0000000B;
    @(negedge Clk);
    CommitValid = 1'b1; ExcpValid = 1'b1; ExcpEcode = 6'h08; CommitPc = 32'h1C000600; BadvValid = 1'b0;
    @(negedge Clk);
    CommitValid = 1'b0; ExcpValid = 1'b0;
    bus.InstCsrWe = 1'b1; bus.InstCsrAddr = 14'h123; bus.InstCsrData = 32'hCAFE0001;
    @(negedge Clk);
    @(negedge Clk);
    #2;
    check("mid.in_estat", bus.WAddr, CSR_ESTAT);
    Rest = 1'b0;
    #1;
    check("mid.wen", bus.WEn, 0);
    check("mid.waddr", bus.WAddr, 0);
    check("mid.wdata", bus.WDate, 0);
    check("mid.stall", TrapStall, 0);
    check("mid.flush", Flush, 0);
    check("mid.redirect", RedirectPc, 0);
    check("mid.ready", bus.InstCsrReady, 0);
    @(negedge Clk);
    Rest = 1'b1;
    #2;
    check("mid.post_wen", bus.WEn, 1);
    check("mid.post_waddr", bus.WAddr, 14'h123);
    check("mid.post_ready", bus.InstCsrReady, 1);
    @(negedge Clk);
    bus.InstCsrWe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #2;
      check("mid.no_flush", Flush, 0);
      check("mid.no_stall", TrapStall, 0);
    end

    for (int i = 0; i < 40; i++) begin
      CsrCrmd      = $urandom;
      CsrEstat     = $urandom;
      if ($urandom_range(0, 2) == 0) CsrEstat[21:16] = 6'h3F;
      CsrEctl      = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      CsrPrmd      = $urandom;
      CsrEra       = $urandom;
      CsrEentry    = $urandom;
      CsrTlbrentry = $urandom;
      runTxn("rnd", $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom), 9'($urandom),
             1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 14'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
